// File: rtl/jkff_bank_sequencer.sv
// jkff_bank_sequencer: round-robin arbiter driving setup/strobe/hold JK ops into a flip-flop bank with a shadow copy
module jkff_bank_sequencer #(
  parameter int NREQ  = 2,
  parameter int WIDTH = 8,
  parameter int IDXW  = 3
) (
  input  logic                 clock,
  input  logic                 r,
  input  logic [NREQ-1:0]      req,
  input  logic [2*NREQ-1:0]    op,
  input  logic [IDXW*NREQ-1:0] idx,
  output logic [NREQ-1:0]      gnt,
  output logic                 err,
  output logic                 busy,
  output logic [WIDTH-1:0]     j,
  output logic [WIDTH-1:0]     k,
  output logic                 ff_ck,
  output logic                 ff_s_n,
  output logic                 ff_r_n,
  output logic [WIDTH-1:0]     shadow
);
  localparam int PW = $clog2(NREQ);
  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;
  state_t state_q, state_d;
  logic [PW-1:0] rr_q, rr_d, win_q, win_d, pick;
  logic [IDXW-1:0] idx_q, idx_d, pick_idx;
  logic [1:0] pick_op;
  logic [NREQ-1:0] gnt_q, gnt_d, rot;
  logic err_q, err_d, busy_q, busy_d, ff_ck_q, ff_ck_d, ff_r_n_q;
  logic [WIDTH-1:0] j_q, j_d, k_q, k_d, shadow_q, shadow_d, mask;
  always_comb begin
    rot = NREQ'({req, req} >> rr_q);
    pick = rr_q;
    for (int i = NREQ - 1; i >= 0; i--) if (rot[i]) pick = PW'((int'(rr_q) + i) % NREQ);
    pick_op = '0;
    pick_idx = '0;
    for (int i = 0; i < NREQ; i++)
      if (pick == PW'(i)) begin
        pick_op = op[2*i +: 2];
        pick_idx = idx[IDXW*i +: IDXW];
      end
    mask = (int'(pick_idx) < WIDTH) ? WIDTH'(1) << pick_idx : '0;
    state_d = state_q;
    rr_d = rr_q;
    win_d = win_q;
    idx_d = idx_q;
    gnt_d = '0;
    err_d = 1'b0;
    busy_d = busy_q;
    j_d = j_q;
    k_d = k_q;
    ff_ck_d = ff_ck_q;
    shadow_d = shadow_q;
    case (state_q)
      IDLE: if (ff_r_n_q && |req) begin
        state_d = SETUP;
        win_d = pick;
        idx_d = pick_idx;
        busy_d = 1'b1;
        j_d = pick_op[1] ? mask : '0;
        k_d = pick_op[0] ? mask : '0;
      end
      SETUP: begin
        state_d = STROBE;
        ff_ck_d = 1'b1;
      end
      // j/k already carry the op, so the shadow follows the JK characteristic equation
      STROBE: begin
        state_d = HOLD;
        gnt_d = NREQ'(1) << win_q;
        err_d = int'(idx_q) >= WIDTH;
        shadow_d = (j_q & ~shadow_q) | (~k_q & shadow_q);
        rr_d = PW'((int'(win_q) + 1) % NREQ);
      end
      default: begin
        state_d = IDLE;
        busy_d = 1'b0;
        j_d = '0;
        k_d = '0;
        ff_ck_d = 1'b0;
      end
    endcase
  end
  always_ff @(posedge clock) begin
    ff_r_n_q <= r;
    if (!r) begin
      state_q <= IDLE;
      rr_q <= '0;
      win_q <= '0;
      idx_q <= '0;
      gnt_q <= '0;
      err_q <= 1'b0;
      busy_q <= 1'b0;
      j_q <= '0;
      k_q <= '0;
      ff_ck_q <= 1'b0;
      shadow_q <= '0;
    end else begin
      state_q <= state_d;
      rr_q <= rr_d;
      win_q <= win_d;
      idx_q <= idx_d;
      gnt_q <= gnt_d;
      err_q <= err_d;
      busy_q <= busy_d;
      j_q <= j_d;
      k_q <= k_d;
      ff_ck_q <= ff_ck_d;
      shadow_q <= shadow_d;
    end
  end
  assign gnt = gnt_q;
  assign err = err_q;
  assign busy = busy_q;
  assign j = j_q;
  assign k = k_q;
  assign ff_ck = ff_ck_q;
  assign ff_s_n = 1'b1;
  assign ff_r_n = ff_r_n_q;
  assign shadow = shadow_q;
endmodule
